// File: rtl/ami_pkg.sv
// ami_pkg: shared AXI read-channel encodings.
//   BURST_*  : ARBURST encodings (FIXED / INCR / WRAP)
//   RESP_*   : RRESP codes (OKAY / EXOKAY / SLVERR / DECERR)
// Widths that depend on the requester count stay local to the arbiter.
package ami_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin arbiter.
//   req : request vector
//   ptr : index holding highest priority this cycle
//   en  : grant enable; gnt is all-zero when low
//   gnt : one-hot grant
//   nxt : pointer to load on grant (winner + 1 mod N), else ptr
module rr_arb #(
    parameter int  N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] nxt
);
    logic [PW-1:0] idx;

    // Scan from the farthest slot back to ptr so the nearest requester wins.
    always_comb begin
        gnt = '0;
        nxt = ptr;
        idx = '0;
        for (int o = N - 1; o >= 0; o--) begin
            idx = PW'((int'(ptr) + o) % N);
            if (en && req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                nxt      = PW'((int'(idx) + 1) % N);
            end
        end
    end
endmodule

// File: rtl/ami_rd_arb.sv
// ami_rd_arb: shares one AXI master read port among NR requesters.
//   ACLK, ARESETn           : clock, asynchronous active-low reset
//   s_ar*                   : per-requester AR channels (round-robin granted)
//   s_r*                    : per-requester R channels (routed by RID index)
//   ARID..ARVALID, ARREADY  : master AR through a one-entry output register
//   RID..RVALID, RREADY     : master R, combinationally demultiplexed
//   rid_err                 : sticky, set by an R beat whose index is >= NR
module ami_rd_arb
    import ami_pkg::*;
#(
    parameter int  NR     = 4,
    parameter int  AXI_DW = 128,
    parameter int  AXI_AW = 32,
    parameter int  AXI_IW = 8,
    parameter int  AXI_LW = 8,
    parameter int  AXI_SW = 3,
    parameter int  AMI_OD = 4,
    localparam int RQ_W   = $clog2(NR)
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [NR-1:0][AXI_IW-1:0]      s_arid,
    input  logic [NR-1:0][AXI_AW-1:0]      s_araddr,
    input  logic [NR-1:0][AXI_LW-1:0]      s_arlen,
    input  logic [NR-1:0][AXI_SW-1:0]      s_arsize,
    input  logic [NR-1:0][1:0]             s_arburst,
    input  logic [NR-1:0]                  s_arvalid,
    output logic [NR-1:0]                  s_arready,
    output logic [NR-1:0][AXI_IW-1:0]      s_rid,
    output logic [NR-1:0][AXI_DW-1:0]      s_rdata,
    output logic [NR-1:0][1:0]             s_rresp,
    output logic [NR-1:0]                  s_rlast,
    output logic [NR-1:0]                  s_rvalid,
    input  logic [NR-1:0]                  s_rready,
    output logic [AXI_IW+RQ_W-1:0]         ARID,
    output logic [AXI_AW-1:0]              ARADDR,
    output logic [AXI_LW-1:0]              ARLEN,
    output logic [AXI_SW-1:0]              ARSIZE,
    output logic [1:0]                     ARBURST,
    output logic                           ARVALID,
    input  logic                           ARREADY,
    input  logic [AXI_IW+RQ_W-1:0]         RID,
    input  logic [AXI_DW-1:0]              RDATA,
    input  logic [1:0]                     RRESP,
    input  logic                           RLAST,
    input  logic                           RVALID,
    output logic                           RREADY,
    output logic                           rid_err
);
    localparam int OW = $clog2(AMI_OD + 1);

    logic [NR-1:0]         elig, gnt, inc, dec;
    logic [NR-1:0][OW-1:0] ost;
    logic [RQ_W-1:0]       ptr, ptr_nxt, g, k;
    logic                  slot_free, acc, k_ok;

    always_comb begin
        for (int i = 0; i < NR; i++) elig[i] = s_arvalid[i] && (int'(ost[i]) < AMI_OD);
    end

    assign slot_free = !ARVALID || ARREADY;

    rr_arb #(.N(NR)) u_arb (
        .req (elig),
        .ptr (ptr),
        .en  (slot_free),
        .gnt (gnt),
        .nxt (ptr_nxt)
    );

    assign s_arready = gnt;
    assign acc       = |gnt;

    always_comb begin
        g = '0;
        for (int i = 0; i < NR; i++) if (gnt[i]) g = RQ_W'(i);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ARVALID <= 1'b0;
            ARID    <= '0;
            ARADDR  <= '0;
            ARLEN   <= '0;
            ARSIZE  <= '0;
            ARBURST <= '0;
            ptr     <= '0;
        end else if (acc) begin
            ARVALID <= 1'b1;
            ARID    <= {g, s_arid[g]};
            ARADDR  <= s_araddr[g];
            ARLEN   <= s_arlen[g];
            ARSIZE  <= s_arsize[g];
            ARBURST <= s_arburst[g];
            ptr     <= ptr_nxt;
        end else if (ARREADY) begin
            ARVALID <= 1'b0;
        end
    end

    // Requester index lives in the top RID bits; out-of-range indices are
    // swallowed (RREADY forced high) so a bad slave cannot stall the bus.
    assign k    = RID[AXI_IW+RQ_W-1 -: RQ_W];
    assign k_ok = int'(k) < NR;

    always_comb begin
        RREADY = !k_ok;
        for (int i = 0; i < NR; i++) begin
            s_rvalid[i] = RVALID && (k == RQ_W'(i));
            s_rid[i]    = RID[AXI_IW-1:0];
            s_rdata[i]  = RDATA;
            s_rresp[i]  = RRESP;
            s_rlast[i]  = RLAST;
            if (k == RQ_W'(i)) RREADY = s_rready[i];
            inc[i] = s_arvalid[i] && s_arready[i];
            dec[i] = s_rvalid[i] && s_rready[i] && RLAST;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ost <= '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (inc[i] && !dec[i]) ost[i] <= ost[i] + 1'b1;
                else if (dec[i] && !inc[i] && ost[i] != '0) ost[i] <= ost[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rid_err <= 1'b0;
        else if (RVALID && !k_ok) rid_err <= 1'b1;
    end
endmodule

// File: tb/tb_ami_rd_arb.sv
// tb_ami_rd_arb: directed scoreboard bench for ami_rd_arb (4-requester main instance,
// plus a 3-requester instance where a 2-bit RID index can exceed NR).
module tb_ami_rd_arb;
    import ami_pkg::*;

    localparam int NR = 4;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [NR-1:0][7:0]   s_arid;
    logic [NR-1:0][31:0]  s_araddr;
    logic [NR-1:0][7:0]   s_arlen;
    logic [NR-1:0][2:0]   s_arsize;
    logic [NR-1:0][1:0]   s_arburst;
    logic [NR-1:0]        s_arvalid, s_arready;
    logic [NR-1:0][7:0]   s_rid;
    logic [NR-1:0][127:0] s_rdata;
    logic [NR-1:0][1:0]   s_rresp;
    logic [NR-1:0]        s_rlast, s_rvalid, s_rready;
    logic [9:0]           ARID, RID;
    logic [31:0]          ARADDR;
    logic [7:0]           ARLEN;
    logic [2:0]           ARSIZE;
    logic [1:0]           ARBURST, RRESP;
    logic                 ARVALID, ARREADY, RLAST, RVALID, RREADY, rid_err;
    logic [127:0]         RDATA;

    ami_rd_arb #(.NR(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY), .rid_err(rid_err)
    );

    logic [2:0][7:0]   t_arid, t_rid_o;
    logic [2:0][31:0]  t_araddr;
    logic [2:0][7:0]   t_arlen;
    logic [2:0][2:0]   t_arsize;
    logic [2:0][1:0]   t_arburst, t_rresp_o;
    logic [2:0]        t_arvalid, t_arready, t_rlast_o, t_rvalid_o, t_rready;
    logic [2:0][127:0] t_rdata_o;
    logic [9:0]        t_ARID, t_RID;
    logic [31:0]       t_ARADDR;
    logic [7:0]        t_ARLEN;
    logic [2:0]        t_ARSIZE;
    logic [1:0]        t_ARBURST, t_RRESP;
    logic              t_ARVALID, t_ARREADY, t_RLAST, t_RVALID, t_RREADY, t_rid_err;
    logic [127:0]      t_RDATA;

    ami_rd_arb #(.NR(3)) dut3 (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_arid(t_arid), .s_araddr(t_araddr), .s_arlen(t_arlen), .s_arsize(t_arsize),
        .s_arburst(t_arburst), .s_arvalid(t_arvalid), .s_arready(t_arready),
        .s_rid(t_rid_o), .s_rdata(t_rdata_o), .s_rresp(t_rresp_o), .s_rlast(t_rlast_o),
        .s_rvalid(t_rvalid_o), .s_rready(t_rready),
        .ARID(t_ARID), .ARADDR(t_ARADDR), .ARLEN(t_ARLEN), .ARSIZE(t_ARSIZE), .ARBURST(t_ARBURST),
        .ARVALID(t_ARVALID), .ARREADY(t_ARREADY),
        .RID(t_RID), .RDATA(t_RDATA), .RRESP(t_RRESP), .RLAST(t_RLAST), .RVALID(t_RVALID),
        .RREADY(t_RREADY), .rid_err(t_rid_err)
    );

    int tests = 0;
    int fails = 0;
    logic [54:0] exp_q[$];
    int mo[NR];
    int rr_order[6] = '{0, 1, 2, 3, 0, 1};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return 32'(32'h1000 + 32'h100 * (i ^ 2));
    endfunction

    function automatic logic [54:0] exp_ar(input int i);
        return {2'(i), 8'(8'h10 + i), addr_of(i), 8'(i + 1), 3'd4, BURST_INCR};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic ar_step(input logic [3:0] valid, input logic [3:0] exp_gnt, input string tag);
        s_arvalid = valid;
        #1;
        check(tag, s_arready, exp_gnt);
        for (int i = 0; i < NR; i++) if (exp_gnt[i]) exp_q.push_back(exp_ar(i));
        tick();
    endtask

    task automatic do_reset();
        ARESETn   = 1'b0;
        s_arvalid = '0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        s_rready  = '1;
        t_RVALID  = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        ARESETn = 1'b1;
        tick();
    endtask

    // AR scoreboard and outstanding-count sanity model, sampled mid-cycle.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < NR; i++) mo[i] = 0;
        end else begin
            if (ARVALID && ARREADY) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL ar_unexpected: observed ARID %0h ARADDR %0h expected no transfer", ARID, ARADDR);
                end else begin
                    check("ar_beat", {ARID, ARADDR, ARLEN, ARSIZE, ARBURST}, exp_q.pop_front());
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (s_rvalid[i] && s_rready[i] && RLAST) begin
                    tests++;
                    assert (mo[i] != 0) else begin
                        fails++;
                        $error("FAIL ost_underflow: requester %0d observed 0 outstanding expected >0", i);
                    end
                    if (mo[i] != 0) mo[i]--;
                end
                if (s_arvalid[i] && s_arready[i]) mo[i]++;
            end
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            s_arid[i]    = 8'(8'h10 + i);
            s_araddr[i]  = addr_of(i);
            s_arlen[i]   = 8'(i + 1);
            s_arsize[i]  = 3'd4;
            s_arburst[i] = BURST_INCR;
        end
        s_arvalid = '0;
        s_rready  = '1;
        ARREADY   = 1'b0;
        RID = '0; RDATA = '0; RRESP = RESP_OKAY; RLAST = 1'b0; RVALID = 1'b0;
        t_arid = '0; t_araddr = '0; t_arlen = '0; t_arsize = '0; t_arburst = '0;
        t_arvalid = '0; t_rready = '0; t_ARREADY = 1'b0;
        t_RID = '0; t_RDATA = '0; t_RRESP = RESP_OKAY; t_RLAST = 1'b0; t_RVALID = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_arvalid", ARVALID, 0);
        check("rst_arid", ARID, 0);
        check("rst_araddr", ARADDR, 0);
        check("rst_arlen", ARLEN, 0);
        check("rst_s_arready", s_arready, 0);
        check("rst_ost", dut.ost, 0);
        check("rst_rid_err", rid_err, 0);
        check("rst_rid_err3", t_rid_err, 0);
        ARESETn = 1'b1;
        tick();

        // Round-robin with all requesters valid
        ARREADY = 1'b1;
        foreach (rr_order[n]) ar_step(4'hF, 4'(1 << rr_order[n]), "rr_gnt");
        s_arvalid = '0;
        tick();
        tick();
        check("rr_drained", exp_q.size(), 0);
        check("rr_arvalid_clear", ARVALID, 0);

        // Single requester and its R burst
        do_reset();
        ARREADY = 1'b1;
        ar_step(4'b0100, 4'b0100, "single_gnt");
        s_arvalid = '0;
        #1;
        check("single_arvalid", ARVALID, 1);
        check("single_arid", ARID, {2'd2, 8'h12});
        check("single_araddr", ARADDR, 32'h1000);
        check("single_arlen", ARLEN, 3);
        tick();
        check("single_arvalid_clear", ARVALID, 0);
        check("single_ost_one", dut.ost[2], 1);
        RID    = {2'd2, 8'h12};
        RVALID = 1'b1;
        for (int b = 0; b < 4; b++) begin
            RDATA = {4{32'hCAFE0000 + 32'(b)}};
            RLAST = (b == 3);
            #1;
            check("single_s_rvalid", s_rvalid, 4'b0100);
            check("single_rready", RREADY, 1);
            check("single_s_rdata", s_rdata[2], {4{32'hCAFE0000 + 32'(b)}});
            check("single_s_rid", s_rid[2], 8'h12);
            check("single_s_rlast", s_rlast[2], (b == 3));
            tick();
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        #1;
        check("single_ost_zero", dut.ost[2], 0);

        // Backpressure on the master AR
        do_reset();
        ar_step(4'b0001, 4'b0001, "bp_first");
        s_arvalid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_s_arready", s_arready, 0);
            check("bp_arvalid", ARVALID, 1);
            check("bp_arid", ARID, {2'd0, 8'h10});
            check("bp_araddr", ARADDR, addr_of(0));
            tick();
        end
        ARREADY = 1'b1;
        ar_step(4'hF, 4'b0010, "bp_resume");
        s_arvalid = '0;
        tick();
        tick();
        check("bp_drained", exp_q.size(), 0);

        // Outstanding limit on requester 1
        do_reset();
        ARREADY = 1'b1;
        repeat (4) ar_step(4'b0010, 4'b0010, "od_fill");
        s_arvalid = 4'b0010;
        #1;
        check("od_stall", s_arready, 0);
        check("od_ost_full", dut.ost[1], 4);
        tick();
        ar_step(4'hF, 4'b0100, "od_others");
        ar_step(4'hF, 4'b1000, "od_others");
        ar_step(4'hF, 4'b0001, "od_others");
        ar_step(4'hF, 4'b0100, "od_skip_full");
        s_arvalid = 4'b0010;
        RID    = {2'd1, 8'h11};
        RVALID = 1'b1;
        RLAST  = 1'b1;
        #1;
        check("od_no_bypass", s_arready, 0);
        check("od_rlast_route", s_rvalid, 4'b0010);
        tick();
        RVALID = 1'b0;
        RLAST  = 1'b0;
        ar_step(4'b0010, 4'b0010, "od_reopen");
        s_arvalid = '0;
        tick();
        tick();
        check("od_drained", exp_q.size(), 0);

        // R backpressure on a valid index
        RID      = {2'd3, 8'h33};
        RDATA    = 128'h1234;
        s_rready = 4'b0111;
        RVALID   = 1'b1;
        #1;
        check("rbp_rready", RREADY, 0);
        check("rbp_s_rvalid", s_rvalid, 4'b1000);
        tick();
        check("rbp_hold_data", s_rdata[3], 128'h1234);
        check("rbp_hold_valid", s_rvalid, 4'b1000);
        s_rready = 4'hF;
        #1;
        check("rbp_release", RREADY, 1);
        tick();
        RVALID = 1'b0;
        check("rbp_no_rid_err", rid_err, 0);

        // Invalid RID index on the 3-requester instance, then a valid one
        t_RID    = {2'd3, 8'h55};
        t_RVALID = 1'b1;
        #1;
        check("inv_rready", t_RREADY, 1);
        check("inv_s_rvalid", t_rvalid_o, 0);
        check("inv_err_not_yet", t_rid_err, 0);
        tick();
        check("inv_rid_err", t_rid_err, 1);
        t_RID    = {2'd2, 8'h55};
        t_rready = 3'b100;
        #1;
        check("inv_valid_route", t_rvalid_o, 3'b100);
        check("inv_valid_rready", t_RREADY, 1);
        tick();
        t_RVALID = 1'b0;
        tick();
        check("inv_rid_err_sticky", t_rid_err, 1);

        // Asynchronous reset with a pending AR and two bursts outstanding
        do_reset();
        ARREADY = 1'b1;
        ar_step(4'b0001, 4'b0001, "mid_a");
        ar_step(4'b0001, 4'b0001, "mid_b");
        s_arvalid = '0;
        ARREADY   = 1'b0;
        #1;
        check("mid_ost_two", dut.ost[0], 2);
        check("mid_arvalid", ARVALID, 1);
        #1;
        ARESETn = 1'b0;
        #1;
        check("mid_rst_arvalid", ARVALID, 0);
        check("mid_rst_ost", dut.ost, 0);
        check("mid_rst_arid", ARID, 0);
        do_reset();
        check("end_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
